// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    function automatic logic is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   start_i;
    logic [1:0]             op_i;
    logic [WIDTH-1:0]       src1_i;
    logic [WIDTH-1:0]       src2_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   busy_o;
    logic                   stall_o;

    modport slave (
        input  start_i, op_i, src1_i, src2_i, annul_i,
        output result_o, ready_o, busy_o, stall_o
    );

    modport master (
        output start_i, op_i, src1_i, src2_i, annul_i,
        input  result_o, ready_o, busy_o, stall_o
    );
endinterface

// File: rtl/mdu_iter_core.sv
// Magnitude datapath: one shift-add (multiply) or restoring shift-subtract
// (divide) step per cycle over the {hi, lo} register pair.
module mdu_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        sum     = {1'b0, hi_q} + {1'b0, b_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (load_i) begin
            hi_d = '0;
            lo_d = a_i;
            b_d  = b_i;
        end else if (step_i) begin
            if (div_i) begin
                // lo holds the dividend shifting out MSB-first and the quotient shifting in
                if (!diff[WIDTH]) begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else if (lo_q[0]) begin
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mdu_iter.sv
// Iterative signed/unsigned multiply/divide unit with start/ready/annul
// handshake; sign handling and sequencing wrap the magnitude core.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      resetn,
    mdu_iter_if.slave bus
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    mdu_state_e           state_q, state_d;
    mdu_op_e              op_q, op_d;
    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    mdu_op_e              op_in;
    logic                 sgn1, sgn2;
    logic [WIDTH-1:0]     abs1, abs2;
    logic                 load, step;
    logic [WIDTH-1:0]     hi, lo;
    logic [2*WIDTH-1:0]   fixed;

    assign op_in = mdu_op_e'(bus.op_i);

    always_comb begin
        sgn1 = is_signed(op_in) & bus.src1_i[WIDTH-1];
        sgn2 = is_signed(op_in) & bus.src2_i[WIDTH-1];
        // Two's-complement negate maps the most negative value onto 2^(W-1)
        abs1 = sgn1 ? -bus.src1_i : bus.src1_i;
        abs2 = sgn2 ? -bus.src2_i : bus.src2_i;
    end

    always_comb begin
        fixed = '0;
        if (is_div(op_q)) begin
            fixed = {(s1_q ? -hi : hi), ((s1_q ^ s2_q) ? -lo : lo)};
        end else begin
            fixed = (s1_q ^ s2_q) ? -{hi, lo} : {hi, lo};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ready_d  = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    op_d  = op_in;
                    s1_d  = sgn1;
                    s2_d  = sgn2;
                    cnt_d = '0;
                    load  = 1'b1;
                    if (is_div(op_in) && (bus.src2_i == '0)) begin
                        state_d  = ST_DONE;
                        result_d = {bus.src1_i, {WIDTH{1'b1}}};
                        ready_d  = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d  = ST_DONE;
                result_d = fixed;
                ready_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides any progress outside IDLE and discards the pending result
        if (bus.annul_i && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            ready_d  = 1'b0;
            step     = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            op_q     <= MDU_MULT;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    mdu_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .resetn (resetn),
        .load_i (load),
        .step_i (step),
        .div_i  (is_div(op_q)),
        .a_i    (abs1),
        .b_i    (abs2),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy_q;
    assign bus.stall_o  = bus.start_i & ~ready_q & ~bus.annul_i;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (WIDTH=32) against a plain-arithmetic reference.
module tb_mdu_iter;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus();

    mdu_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [63:0] res;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    logic [63:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: return sa * sb;
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Monitor: stall equation every cycle, results popped whenever ready_o pulses
    always @(negedge clk) begin
        chk("stall", 64'(bus.stall_o), 64'(bus.start_i & ~bus.ready_o & ~bus.annul_i));
        if (bus.ready_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ready", 64'(bus.ready_o), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", bus.result_o, e.res);
                chk("ready_cycle", 64'(cyc), 64'(e.due));
                last_res = e.res;
            end
        end
    end

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (bus.busy_o !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'(bus.busy_o), 64'd0);
    endtask

    // Called at posedge+#1; hold=1 keeps start_i high through the ready cycle
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold);
        int unsigned n;
        exp_t        e;
        wait_idle();
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        e.res = model(op, a, b);
        e.due = cyc + ((op[1] && b == 32'd0) ? 1 : 34);
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk("busy_after_accept", 64'(bus.busy_o), 64'd1);
        if (!hold) begin
            bus.start_i = 1'b0;
            bus.src1_i  = $urandom;
            bus.src2_i  = $urandom;
        end else begin
            n = 0;
            @(negedge clk);
            while (bus.ready_o !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) chk("ready_timeout", 64'(bus.ready_o), 64'd1);
            @(posedge clk); #1;
            bus.start_i = 1'b0;
        end
    endtask

    initial begin
        int unsigned c, n;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        bus.start_i = 1'b0;
        bus.op_i    = 2'd0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.annul_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", bus.result_o, 64'd0);
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_busy", 64'(bus.busy_o), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(2'd0, -32'sd3, 32'd7, 1'b0);
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(2'd2, -32'sd7, 32'd2, 1'b0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(2'd3, 32'd7, 32'd2, 1'b0);
        issue(2'd3, 32'd100, 32'd0, 1'b1);
        issue(2'd2, -32'sd5, 32'd0, 1'b0);

        // Annul a DIV ten cycles in, then accept a MULTU the next cycle
        wait_idle();
        c = cyc;
        bus.start_i = 1'b1;
        bus.op_i    = 2'd2;
        bus.src1_i  = -32'sd100;
        bus.src2_i  = 32'd7;
        while (cyc < c + 10) begin
            @(posedge clk); #1;
        end
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        chk("annul_busy", 64'(bus.busy_o), 64'd0);
        chk("annul_result_kept", bus.result_o, last_res);
        issue(2'd1, 32'd6, 32'd7, 1'b0);

        // start and annul together in IDLE: must not be accepted
        wait_idle();
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        bus.op_i    = 2'd1;
        bus.src1_i  = 32'd3;
        bus.src2_i  = 32'd3;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        chk("idle_annul_busy", 64'(bus.busy_o), 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // Asynchronous reset five cycles into a MULT
        c = cyc;
        bus.start_i = 1'b1;
        bus.op_i    = 2'd0;
        bus.src1_i  = -32'sd1234;
        bus.src2_i  = 32'd77;
        while (cyc < c + 5) begin
            @(posedge clk); #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_result", bus.result_o, 64'd0);
        chk("arst_ready", 64'(bus.ready_o), 64'd0);
        chk("arst_busy", 64'(bus.busy_o), 64'd0);
        bus.start_i = 1'b0;
        #1;
        chk("arst_stall", 64'(bus.stall_o), 64'd0);
        last_res = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        issue(2'd0, -32'sd1234, 32'd77, 1'b1);
        repeat (40) @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
